ld_cell_monitor: RTL and testbench



---
 rtl/ld_mon_pkg.sv | 13 +
 rtl/ld_cell_monitor_avg4.sv | 30 +++
 rtl/ld_cell_monitor.sv | 163 ++++++++++++++++
 tb/tb_ld_cell_monitor.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ld_mon_pkg.sv
// Shared types and widths for the load-cell monitor.
package ld_mon_pkg;

   localparam int unsigned SUM_W = 13;
   localparam int unsigned CMP_W = 17;

   typedef enum logic [1:0] {
      NO_RIDER = 2'd0,
      WAIT     = 2'd1,
      STEER_EN = 2'd2
   } steer_state_t;

endpackage

// File: rtl/ld_cell_monitor_avg4.sv
// One 12-bit 4-tap running average. The accumulator always holds the sum of the four taps.
module ld_avg4 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        shift_i,
   input  logic [11:0] sample_i,
   output logic [11:0] avg_o
);

   logic [11:0] tap_q [4];
   logic [13:0] acc_q, acc_d;

   // Window for this frame: the new sample plus the three youngest taps.
   always_comb begin
      acc_d = acc_q + 14'(sample_i) - 14'(tap_q[3]);
      avg_o = acc_d[13:2];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
         for (int i = 0; i < 4; i++) tap_q[i] <= '0;
      end else if (shift_i) begin
         acc_q    <= acc_d;
         tap_q[0] <= sample_i;
         for (int i = 1; i < 4; i++) tap_q[i] <= tap_q[i-1];
      end
   end

endmodule

// File: rtl/ld_cell_monitor.sv
// Paces the A2D with nxt pulses and qualifies rider presence, steering and battery once per frame.
// Define LD_AVG_EN to evaluate on 4-frame running averages of the load cells.
module ld_cell_monitor
   import ld_mon_pkg::*;
#(
   parameter int unsigned PERIOD       = 2048,
   parameter logic [12:0] MIN_RIDER_WT = 13'h200,
   parameter logic [12:0] WT_HYST      = 13'h040,
   parameter logic [15:0] STEER_FRAMES = 16'd330,
   parameter logic [11:0] BATT_THRES   = 12'h800,
   parameter logic [2:0]  BATT_DEB     = 3'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   input  logic [11:0] batt,
   output logic        nxt,
   output logic [12:0] ld_sum,
   output logic        rider_off,
   output logic        en_steer,
   output logic        batt_low
);

   localparam int unsigned TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(PERIOD - 1);
   localparam logic [SUM_W-1:0] ON_THR  = MIN_RIDER_WT + WT_HYST;
   localparam logic [SUM_W-1:0] OFF_THR = MIN_RIDER_WT - WT_HYST;

   logic [TMR_W-1:0] timer_q;
   logic [1:0]       chan_idx_q;
   logic             primed_q;
   steer_state_t     state_q, state_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic [2:0]       low_cnt_q, low_cnt_d;
   logic [12:0]      ld_sum_q, ld_sum_d;
   logic             rider_off_q, rider_off_d;
   logic             en_steer_q, en_steer_d;

   logic             eval, upd;
   logic [11:0]      lft_s, rght_s, diff;
   logic [SUM_W-1:0] sum;
   logic [CMP_W-1:0] sum_x, diff4, diff16, sum15;
   logic             balanced, stepping_off;

   assign nxt  = (timer_q == TMR_MAX);
   assign eval = nxt && (chan_idx_q == 2'd2);
   // The first eval after reset sees unreset A2D registers, so it only primes.
   assign upd  = eval && primed_q;

`ifdef LD_AVG_EN
   ld_avg4 u_avg_lft (
      .clk_i   (clk),
      .rst_i   (rst),
      .shift_i (upd),
      .sample_i(lft_ld),
      .avg_o   (lft_s)
   );
   ld_avg4 u_avg_rght (
      .clk_i   (clk),
      .rst_i   (rst),
      .shift_i (upd),
      .sample_i(rght_ld),
      .avg_o   (rght_s)
   );
`else
   assign lft_s  = lft_ld;
   assign rght_s = rght_ld;
`endif

   always_comb begin
      sum          = {1'b0, lft_s} + {1'b0, rght_s};
      diff         = (lft_s >= rght_s) ? (lft_s - rght_s) : (rght_s - lft_s);
      sum_x        = CMP_W'(sum);
      diff4        = CMP_W'({diff, 2'b00});
      diff16       = CMP_W'({diff, 4'b0000});
      sum15        = (sum_x << 4) - sum_x;
      balanced     = (diff4 < sum_x);
      stepping_off = (diff16 > sum15);
   end

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      low_cnt_d   = low_cnt_q;
      ld_sum_d    = ld_sum_q;
      rider_off_d = rider_off_q;
      if (upd) begin
         ld_sum_d = sum;
         if (sum > ON_THR) begin
            rider_off_d = 1'b0;
         end else if (sum < OFF_THR) begin
            rider_off_d = 1'b1;
         end

         case (state_q)
            NO_RIDER: begin
               if (!rider_off_d) begin
                  state_d     = WAIT;
                  frame_cnt_d = '0;
               end
            end
            WAIT: begin
               if (rider_off_d) begin
                  state_d = NO_RIDER;
               end else if (!balanced) begin
                  frame_cnt_d = '0;
               end else if (frame_cnt_q >= STEER_FRAMES - 16'd1) begin
                  state_d = STEER_EN;
               end else if (frame_cnt_q != 16'hFFFF) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end
            end
            STEER_EN: begin
               if (rider_off_d) begin
                  state_d = NO_RIDER;
               end else if (stepping_off) begin
                  state_d     = WAIT;
                  frame_cnt_d = '0;
               end
            end
            default: state_d = NO_RIDER;
         endcase

         if (batt < BATT_THRES) begin
            low_cnt_d = (low_cnt_q >= BATT_DEB) ? BATT_DEB : low_cnt_q + 3'd1;
         end else begin
            low_cnt_d = '0;
         end
      end
      en_steer_d = (state_d == STEER_EN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q     <= '0;
         chan_idx_q  <= '0;
         primed_q    <= 1'b0;
         state_q     <= NO_RIDER;
         frame_cnt_q <= '0;
         low_cnt_q   <= '0;
         ld_sum_q    <= '0;
         rider_off_q <= 1'b1;
         en_steer_q  <= 1'b0;
      end else begin
         timer_q     <= nxt ? '0 : timer_q + 1'b1;
         if (nxt) chan_idx_q <= (chan_idx_q == 2'd2) ? 2'd0 : chan_idx_q + 2'd1;
         if (eval) primed_q <= 1'b1;
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         low_cnt_q   <= low_cnt_d;
         ld_sum_q    <= ld_sum_d;
         rider_off_q <= rider_off_d;
         en_steer_q  <= en_steer_d;
      end
   end

   assign ld_sum    = ld_sum_q;
   assign rider_off = rider_off_q;
   assign en_steer  = en_steer_q;
   assign batt_low  = (low_cnt_q == BATT_DEB);

endmodule

// File: tb/tb_ld_cell_monitor.sv
// Directed bench for ld_cell_monitor (default build): pacing, rider/steer qualification, battery, reset.
module tb_ld_cell_monitor;

   // Shortened pacing period keeps the run short; frame structure is unchanged.
   localparam int unsigned P     = 512;
   localparam int unsigned FRAME = 3 * P;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] lft_ld, rght_ld, batt;
   logic        nxt;
   logic [12:0] ld_sum;
   logic        rider_off, en_steer, batt_low;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   ld_cell_monitor #(
      .PERIOD      (P),
      .STEER_FRAMES(16'd4)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .lft_ld   (lft_ld),
      .rght_ld  (rght_ld),
      .batt     (batt),
      .nxt      (nxt),
      .ld_sum   (ld_sum),
      .rider_off(rider_off),
      .en_steer (en_steer),
      .batt_low (batt_low)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Advance to the next frame-completing nxt; bounded by FRAME cycles.
   task automatic to_eval();
      step();
      while (cyc % FRAME != 0) step();
      check_eq("nxt_at_eval", 16'(nxt), 16'd1);
   endtask

   task automatic check_outs(input string tag, input logic [12:0] sum_e, input logic ro_e,
                             input logic es_e, input logic bl_e);
      check_eq({tag, "_ld_sum"}, 16'(ld_sum), 16'(sum_e));
      check_eq({tag, "_rider_off"}, 16'(rider_off), 16'(ro_e));
      check_eq({tag, "_en_steer"}, 16'(en_steer), 16'(es_e));
      check_eq({tag, "_batt_low"}, 16'(batt_low), 16'(bl_e));
   endtask

   task automatic eval_chk(input string tag, input logic [12:0] sum_e, input logic ro_e,
                           input logic es_e, input logic bl_e);
      to_eval();
      step();
      check_outs(tag, sum_e, ro_e, es_e, bl_e);
   endtask

   initial begin
      rst     = 1'b1;
      lft_ld  = 12'h200;
      rght_ld = 12'h200;
      batt    = 12'hFFF;
      step();
      rst = 1'b0;
      cyc = 1;
      check_eq("rst_nxt", 16'(nxt), 16'd0);
      check_outs("rst", 13'h0, 1'b1, 1'b0, 1'b0);

      // nxt only at cycles P, 2P, 3P, each one clock wide
      while (cyc <= FRAME + 40) begin
         check_eq("nxt_pace", 16'(nxt), 16'(cyc % P == 0));
         step();
      end
      check_outs("prime", 13'h0, 1'b1, 1'b0, 1'b0);

      to_eval();
      check_eq("pre_eval2_rider_off", 16'(rider_off), 16'd1);
      step();
      check_outs("rider_on", 13'h400, 1'b0, 1'b0, 1'b0);
      eval_chk("wait1", 13'h400, 1'b0, 1'b0, 1'b0);
      eval_chk("wait2", 13'h400, 1'b0, 1'b0, 1'b0);
      eval_chk("wait3", 13'h400, 1'b0, 1'b0, 1'b0);
      eval_chk("steer_on", 13'h400, 1'b0, 1'b1, 1'b0);

      lft_ld = 12'h0F0; rght_ld = 12'h0F0;
      eval_chk("hyst_hold", 13'h1E0, 1'b0, 1'b1, 1'b0);
      lft_ld = 12'h0D8; rght_ld = 12'h0D8;
      eval_chk("hyst_off", 13'h1B0, 1'b1, 1'b0, 1'b0);

      lft_ld = 12'h200; rght_ld = 12'h200; batt = 12'h7FF;
      eval_chk("batt_l1", 13'h400, 1'b0, 1'b0, 1'b0);
      eval_chk("batt_l2", 13'h400, 1'b0, 1'b0, 1'b0);
      eval_chk("batt_l3", 13'h400, 1'b0, 1'b0, 1'b0);
      batt = 12'h800;
      eval_chk("batt_thres", 13'h400, 1'b0, 1'b0, 1'b0);
      batt = 12'h7FF;
      eval_chk("resteer", 13'h400, 1'b0, 1'b1, 1'b0);

      lft_ld = 12'h3F0; rght_ld = 12'h008;
      eval_chk("step_off", 13'h3F8, 1'b0, 1'b0, 1'b0);
      lft_ld = 12'h200; rght_ld = 12'h200;
      eval_chk("requal1", 13'h400, 1'b0, 1'b0, 1'b0);
      eval_chk("batt_low4", 13'h400, 1'b0, 1'b0, 1'b1);
      eval_chk("requal3", 13'h400, 1'b0, 1'b0, 1'b1);
      eval_chk("requal4", 13'h400, 1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 100; i++) step();
      rst = 1'b1;
      step();
      check_eq("midrst_nxt", 16'(nxt), 16'd0);
      check_outs("midrst", 13'h0, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      cyc = 1;
      to_eval();
      step();
      check_outs("reprime", 13'h0, 1'b1, 1'b0, 1'b0);
      eval_chk("post_rst", 13'h400, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
